// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into W-bit words and writes them into
// the CPU instruction RAM. Define IMEM_LOADER_CKSUM_EN to enable the trailer checksum.
module imem_loader #(
  parameter int M = 7,
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M:0]   word_count,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic [M-1:0] fetch_addr,
  output logic [W-1:0] fetch_data,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] load_addr,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_idx;
  logic [15:0] word_lo;
  logic [M:0]  words_left;
  logic [W-1:0] mem [2**M];

  logic xfer;
  logic start_ok;
  logic word_done;
  logic last_word;

  assign xfer      = in_valid && in_ready;
  assign start_ok  = (state == IDLE) && start && (word_count != '0);
  assign word_done = (state == LOAD) && xfer && (byte_idx == 2'd2);
  assign last_word = word_done && (words_left == (M+1)'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of process ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: if (start_ok) state_next = LOAD;
      LOAD: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
      CHECK: if (xfer) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: all handshake/status outputs are decoded from state alone.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      LOAD, CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Byte packing, address and word counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx   <= 2'd0;
      word_lo    <= '0;
      words_left <= '0;
      load_addr  <= '0;
    end else if (start_ok) begin
      byte_idx   <= 2'd0;
      words_left <= word_count;
      load_addr  <= '0;
    end else if ((state == LOAD) && xfer) begin
      unique case (byte_idx)
        2'd0: begin
          word_lo[7:0] <= in_data;
          byte_idx     <= 2'd1;
        end
        2'd1: begin
          word_lo[15:8] <= in_data;
          byte_idx      <= 2'd2;
        end
        default: begin
          byte_idx   <= 2'd0;
          load_addr  <= load_addr + 1'b1;
          words_left <= words_left - (M+1)'(1);
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] sum;

  // Running sum covers the full byte, including bits dropped from the top of the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
      err <= 1'b0;
    end else if (start_ok) begin
      sum <= '0;
      err <= 1'b0;
    end else if ((state == LOAD) && xfer) begin
      sum <= sum + in_data;
    end else if ((state == CHECK) && xfer) begin
      err <= (in_data != sum);
    end
  end
`else
  assign err = 1'b0;
`endif

  // NOTE: the RAM has no reset; a reset mid-load must leave already written words intact.
  always_ff @(posedge clk) begin
    if (word_done) mem[load_addr] <= {in_data[W-17:0], word_lo};
  end

  assign fetch_data = mem[fetch_addr];

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected done/readback results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_loader;
  localparam int M = 7;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [M:0]   word_count;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [M-1:0] fetch_addr;
  logic [W-1:0] fetch_data;
  logic         busy;
  logic         done;
  logic [M-1:0] load_addr;
  logic         err;

  imem_loader #(.M(M), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .busy(busy),
    .done(done), .load_addr(load_addr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0] addr;
    logic         err;
  } done_exp_t;

  typedef struct {
    logic [M-1:0] addr;
    logic [W-1:0] data;
  } rd_exp_t;

  done_exp_t done_q[$];
  rd_exp_t   rd_q[$];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_count = 0;
  int   busy_cycles = 0;
  logic rd_req = 1'b0;
  logic [7:0] tb_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin : monitor
    done_exp_t de;
    rd_exp_t   re;
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) begin
      done_count++;
      if (done_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with load_addr=%0h, expected no pulse", load_addr);
      end else begin
        de = done_q.pop_front();
        check("done_load_addr", 32'(load_addr), 32'(de.addr));
        check("done_err", 32'(err), 32'(de.err));
      end
    end
    if (rd_req) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL readback_queue: read request with no expected value");
      end else begin
        re = rd_q.pop_front();
        check($sformatf("fetch_data[%0d]", re.addr), 32'(fetch_data), 32'(re.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input int addr, input logic e);
    done_exp_t d;
    d.addr = addr[M-1:0];
    d.err  = e;
    done_q.push_back(d);
  endtask

  task automatic do_start(input int wc);
    word_count = wc[M:0];
    tb_sum     = 8'h00;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_raw(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    n_fail++;
    $display("FAIL send_timeout: in_ready=%b for 20 cycles, expected 1", in_ready);
  endtask

  task automatic send_data(input logic [7:0] b);
    tb_sum = tb_sum + b;
    send_raw(b);
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CKSUM_EN
    send_raw(tb_sum);
`endif
  endtask

  task automatic readback(input int addr, input logic [W-1:0] exp);
    rd_exp_t r;
    r.addr = addr[M-1:0];
    r.data = exp;
    rd_q.push_back(r);
    fetch_addr = addr[M-1:0];
    rd_req     = 1'b1;
    tick();
    rd_req     = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int dc;
    int bc0;
    logic [7:0] iv;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    word_count = '0; fetch_addr = '0; tb_sum = '0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_load_addr", 32'(load_addr), 0);
    tick();
    reset = 1'b0;
    tick();

    // Single word, done one cycle after the last accepted byte
    expect_done(1, 1'b0);
    do_start(1);
    check("load_busy", 32'(busy), 1);
    send_data(8'h34); send_data(8'h12); send_data(8'h03);
    finish_load();
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 1);
    check("t1_busy_in_done", 32'(busy), 0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 0);
    readback(0, 18'h31234);

    // Two words with a two-cycle stall between bytes 2 and 3
    expect_done(2, 1'b0);
    do_start(2);
    send_data(8'h01); send_data(8'h00);
    tick();
    check("t2_stall_load_addr", 32'(load_addr), 0);
    tick();
    send_data(8'hFF);
    check("t2_load_addr_after_w0", 32'(load_addr), 1);
    readback(0, 18'h30001);
    send_data(8'h02); send_data(8'h00); send_data(8'h00);
    finish_load();
    @(negedge clk);
    check("t2_done_pulse", 32'(done), 1);
    readback(1, 18'h00002);

    // Start ignored during LOAD; zero-count start ignored in IDLE
    expect_done(1, 1'b0);
    do_start(1);
    send_data(8'hAA);
    word_count = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_busy_after_start", 32'(busy), 1);
    check("t3_load_addr_after_start", 32'(load_addr), 0);
    send_data(8'hBB); send_data(8'hCC);
    finish_load();
    @(negedge clk);
    check("t3_done_pulse", 32'(done), 1);
    readback(0, 18'h0BBAA);
    dc = done_count;
    do_start(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_zero_start_busy", 32'(busy), 0);
    end
    check("t3_zero_start_no_done", 32'(done_count), 32'(dc));
    tick();

    // Reset after 4 of 6 bytes
    do_start(2);
    send_data(8'h11); send_data(8'h22); send_data(8'h01); send_data(8'h44);
    reset = 1'b1;
    #1;
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_load_addr", 32'(load_addr), 0);
    check("t4_rst_in_ready", 32'(in_ready), 0);
    tick();
    reset = 1'b0;
    readback(0, 18'h12211);
    readback(1, 18'h00002);

    // Full 128-word image, address wraps to 0
    expect_done(0, 1'b0);
    bc0 = busy_cycles;
    do_start(128);
    for (int i = 0; i < 128; i++) begin
      iv = 8'(i);
      send_data(iv);
      send_data(iv ^ 8'h5A);
      send_data({6'b0, iv[1:0]});
    end
    finish_load();
    @(negedge clk);
    check("t5_done_pulse", 32'(done), 1);
`ifdef IMEM_LOADER_CKSUM_EN
    check("t5_busy_cycles", 32'(busy_cycles - bc0), 385);
`else
    check("t5_busy_cycles", 32'(busy_cycles - bc0), 384);
`endif
    for (int i = 0; i < 128; i++) begin
      iv = 8'(i);
      readback(i, {iv[1:0], iv ^ 8'h5A, iv});
    end

`ifdef IMEM_LOADER_CKSUM_EN
    // Trailer checksum: good trailer, bad trailer, err held until next start
    expect_done(1, 1'b0);
    do_start(1);
    send_data(8'h10); send_data(8'h20); send_data(8'h30);
    send_raw(8'h60);
    @(negedge clk);
    check("t6_good_done", 32'(done), 1);
    check("t6_good_err", 32'(err), 0);
    tick();
    expect_done(1, 1'b1);
    do_start(1);
    send_data(8'h10); send_data(8'h20); send_data(8'h30);
    send_raw(8'h61);
    @(negedge clk);
    check("t6_bad_done", 32'(done), 1);
    check("t6_bad_err", 32'(err), 1);
    tick(); tick(); tick();
    check("t6_err_held", 32'(err), 1);
    expect_done(1, 1'b0);
    do_start(1);
    check("t6_err_cleared_by_start", 32'(err), 0);
    send_data(8'h01); send_data(8'h02); send_data(8'h03);
    finish_load();
    @(negedge clk);
    check("t6_final_done", 32'(done), 1);
`endif

    tick(); tick();
    check("done_queue_drained", 32'(done_q.size()), 0);
    check("read_queue_drained", 32'(rd_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the CPU instruction memory. It accepts a byte stream over a valid/ready handshake and packs every three bytes into one 18-bit instruction word.
- It writes each word into an internal instruction RAM. The RAM replaces the read-only instruction store.
- The CPU fetch path reads the same RAM through a combinational port.
- busy tells the CPU to hold the PC while a program image is being loaded.

Parameters:
- M, 7, address width; RAM depth is 2**M words.
- W, 18, instruction word width; legal range 17..24 (always three bytes per word).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a load; sampled in IDLE only.
- word_count  input  M+1  number of words to load; legal range 1..2**M.
- in_valid  input  1  in_data carries a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- fetch_addr  input  M  CPU fetch address.
- fetch_data  output  W  mem[fetch_addr], combinational.
- busy  output  1  load in progress; CPU holds the PC while high.
- done  output  1  one-cycle pulse when a load completes.
- load_addr  output  M  address of the next word to be written.
- err  output  1  checksum mismatch (see Optional Feature).

Behaviour:
- Reset (async, active-high) sets:
  - state=IDLE, byte_idx=0;
  - in_ready=0, busy=0, done=0, err=0, load_addr=0;
  - internal word count=0.
  - RAM contents are not cleared by reset.
- States: IDLE, LOAD, CHECK (only when CKSUM_EN is defined), DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 with word_count!=0: latch word_count, load_addr<=0, byte_idx<=0, err<=0, clear the running sum, go to LOAD.
  - start=1 with word_count=0: ignored; stay in IDLE; no done pulse.
- LOAD:
  - busy=1, in_ready=1.
  - A byte transfers on a posedge where in_valid and in_ready are both high. No transfer means no state change.
  - byte_idx=0: byte goes to word bits [7:0].
  - byte_idx=1: byte goes to word bits [15:8].
  - byte_idx=2: in_data[W-17:0] goes to word bits [W-1:16]; remaining upper bits of the byte are ignored.
  - On the byte_idx=2 transfer, the same edge writes mem[load_addr] with the fully assembled word. It also increments load_addr and sets byte_idx back to 0.
  - When the word just written is number word_count: go to CHECK if CKSUM_EN is defined, otherwise DONE. in_ready drops the next cycle.
  - load_addr wraps mod 2**M. Wrap only occurs when word_count=2**M, where it lands on 0 at completion.
  - start is ignored in every state except IDLE.
- DONE:
  - done=1 for exactly one cycle, busy=0, in_ready=0.
  - Next state is IDLE.
- Fetch port:
  - fetch_data = mem[fetch_addr] at all times, including during LOAD.
  - A word written at edge N is visible on fetch_data after edge N.
- Reset during LOAD aborts the load. Words already written stay in RAM; the partial word is discarded.
- Throughput: one byte per cycle; a word completes every 3 accepted bytes.

Optional Feature:
- Macro IMEM_LOADER_CKSUM_EN.
- Defined:
  - A running 8-bit sum (mod 256) accumulates every data byte accepted in LOAD, including ignored upper bits.
  - CHECK state: busy=1, in_ready=1; waits for exactly one trailer byte.
  - On trailer transfer, err<=1 if trailer != sum, else err<=0. Then go to DONE.
  - err stays valid until the next accepted start or reset.
- Undefined:
  - No CHECK state and no sum register; LOAD goes directly to DONE.
  - err is held at 0.

Test Plan:
- Reset, then start with word_count=1 and bytes 0x34,0x12,0x03 at one per cycle:
  - mem[0]=18'h31234;
  - done pulses exactly 1 cycle after the 3rd byte's edge (+1 cycle if CKSUM_EN);
  - fetch_addr=0 gives 18'h31234.
- word_count=2, bytes 0x01,0x00,0xFF,0x02,0x00,0x00 with in_valid dropped for 2 cycles between bytes 2 and 3:
  - mem[0]=18'h30001, mem[1]=18'h00002;
  - load_addr=2 at done; stall cycles do not advance byte_idx.
- start pulsed during LOAD and start with word_count=0 in IDLE:
  - both ignored; busy and load_addr unaffected;
  - no done pulse for the zero-count start.
- Assert reset after 4 of 6 bytes (word_count=2):
  - busy=0, load_addr=0 immediately;
  - mem[0] keeps the word written before reset; mem[1] is unchanged.
- word_count=2**M (128), full image of 384 bytes:
  - all 128 words read back correctly;
  - load_addr wraps to 0;
  - busy is high for 384 accepted-byte cycles.
- CKSUM_EN, bytes 0x10,0x20,0x30 then trailer 0x60:
  - err=0, done pulses.
  - Repeat with trailer 0x61: err=1 and held until the next start.
